// File: rtl/wram_arbiter.sv
// Arbitrates a single-port WRAM BSRAM between the NES CPU/loader byte port and a RV halfword toggle port.
// Latency: CPU write valid 2 cycles, CPU read valid 3 cycles, RV ack 4 cycles after the request toggle is sampled (uncontested).
// Backpressure: CPU requests queue as one pending slot (a newer strobe overwrites it); RV holds its toggle until acknowledged.
module wram_arbiter #(
    parameter int          P_WRAM_SIZE  = 8192,
    parameter logic [15:0] P_NES_BASE   = 16'h6000,
    parameter logic [22:0] P_RV_BASE    = 23'h066000,
    parameter int          P_RV_MAXWAIT = 8,
    localparam int         LP_AW        = $clog2(P_WRAM_SIZE)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [15:0]      i_cpu_addr,
    input  logic             i_cpu_re,
    input  logic             i_cpu_we,
    input  logic [7:0]       i_cpu_wdata,
    output logic [7:0]       o_cpu_rdata,
    output logic             o_cpu_valid,
    input  logic             i_rv_req,
    output logic             o_rv_req_ack,
    input  logic [22:0]      i_rv_addr,
    input  logic             i_rv_we,
    input  logic [15:0]      i_rv_wdata,
    input  logic [1:0]       i_rv_ds,
    output logic [15:0]      o_rv_rdata,
    input  logic             i_wram_load_ongoing,
    output logic             o_bsram_en,
    output logic             o_bsram_we,
    output logic [LP_AW-1:0] o_bsram_addr,
    output logic [7:0]       o_bsram_wdata,
    input  logic [7:0]       i_bsram_rdata
);

    localparam int LP_WW = $clog2(P_RV_MAXWAIT + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CPU_ACC = 3'd1,
        S_CPU_RD  = 3'd2,
        S_RV_LO   = 3'd3,
        S_RV_HI   = 3'd4,
        S_RV_DONE = 3'd5
    } state_t;

    state_t             r_state;

    // Latched CPU request (single slot, newest strobe wins)
    logic               r_cpu_pend;
    logic [LP_AW-1:0]   r_cpu_off;
    logic               r_cpu_we;
    logic [7:0]         r_cpu_wdata;
    logic [7:0]         r_cpu_rdata;
    logic               r_cpu_valid;

    // RV request, sampled at grant; only the halfword part of the offset is kept
    logic               r_rv_req_s;
    logic               r_rv_ack;
    logic [LP_AW-1:1]   r_rv_hw;
    logic               r_rv_we;
    logic [15:0]        r_rv_wdata;
    logic [1:0]         r_rv_ds;
    logic [15:0]        r_rv_rdata;
    logic [LP_WW-1:0]   r_rv_wait;

    // Registered BSRAM port
    logic               r_bsram_en;
    logic               r_bsram_we;
    logic [LP_AW-1:0]   r_bsram_addr;
    logic [7:0]         r_bsram_wdata;

    // Window decode: subtracting the base makes anything below it wrap to a huge value
    logic [16:0]        w_cpu_off;
    logic               w_cpu_in_win;
    logic               w_cpu_stb;
    logic [23:0]        w_rv_off;
    logic               w_rv_in_win;
    logic               w_rv_pend;
    logic               w_rv_wait_full;
    logic               w_rv_wins;
    logic               w_rv_in_svc;

    assign w_cpu_off      = {1'b0, i_cpu_addr} - {1'b0, P_NES_BASE};
    assign w_cpu_in_win   = (w_cpu_off < 17'(P_WRAM_SIZE));
    assign w_cpu_stb      = (i_cpu_re | i_cpu_we) & w_cpu_in_win;

    assign w_rv_off       = {1'b0, i_rv_addr} - {1'b0, P_RV_BASE};
    assign w_rv_in_win    = (w_rv_off < 24'(P_WRAM_SIZE));
    // The toggle is compared after one register stage so the ack lands 4 cycles after sampling
    assign w_rv_pend      = (r_rv_req_s != r_rv_ack) & w_rv_in_win;
    assign w_rv_wait_full = (r_rv_wait >= LP_WW'(P_RV_MAXWAIT));
    assign w_rv_wins      = w_rv_pend & (i_wram_load_ongoing | ~r_cpu_pend | w_rv_wait_full);
    assign w_rv_in_svc    = (r_state == S_RV_LO) | (r_state == S_RV_HI) | (r_state == S_RV_DONE);

    assign o_cpu_rdata    = r_cpu_rdata;
    assign o_cpu_valid    = r_cpu_valid;
    assign o_rv_req_ack   = r_rv_ack;
    assign o_rv_rdata     = r_rv_rdata;
    assign o_bsram_en     = r_bsram_en;
    assign o_bsram_we     = r_bsram_we;
    assign o_bsram_addr   = r_bsram_addr;
    assign o_bsram_wdata  = r_bsram_wdata;

    // Arbitration FSM with request capture, wait counter and registered BSRAM/response outputs
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_cpu_pend    <= 1'b0;
            r_cpu_off     <= '0;
            r_cpu_we      <= 1'b0;
            r_cpu_wdata   <= '0;
            r_cpu_rdata   <= '0;
            r_cpu_valid   <= 1'b0;
            // Ack follows req so nothing is pending when reset drops
            r_rv_req_s    <= i_rv_req;
            r_rv_ack      <= i_rv_req;
            r_rv_hw       <= '0;
            r_rv_we       <= 1'b0;
            r_rv_wdata    <= '0;
            r_rv_ds       <= '0;
            r_rv_rdata    <= '0;
            r_rv_wait     <= '0;
            r_bsram_en    <= 1'b0;
            r_bsram_we    <= 1'b0;
            r_bsram_addr  <= '0;
            r_bsram_wdata <= '0;
        end else begin
            r_cpu_valid <= 1'b0;
            r_rv_req_s  <= i_rv_req;

            // Count cycles an RV request is left waiting, saturating at the force threshold
            if (r_state == S_RV_DONE) begin
                r_rv_wait <= '0;
            end else if (w_rv_pend && !w_rv_in_svc && !((r_state == S_IDLE) && w_rv_wins)
                         && !w_rv_wait_full) begin
                r_rv_wait <= r_rv_wait + 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_rv_wins) begin
                        r_rv_hw       <= w_rv_off[LP_AW-1:1];
                        r_rv_we       <= i_rv_we;
                        r_rv_wdata    <= i_rv_wdata;
                        r_rv_ds       <= i_rv_ds;
                        r_bsram_addr  <= {w_rv_off[LP_AW-1:1], 1'b0};
                        r_bsram_en    <= i_rv_we ? i_rv_ds[0] : 1'b1;
                        r_bsram_we    <= i_rv_we;
                        r_bsram_wdata <= i_rv_wdata[7:0];
                        r_state       <= S_RV_LO;
                    end else if (r_cpu_pend) begin
                        r_cpu_pend    <= 1'b0;
                        r_bsram_addr  <= r_cpu_off;
                        r_bsram_en    <= 1'b1;
                        r_bsram_we    <= r_cpu_we;
                        r_bsram_wdata <= r_cpu_wdata;
                        r_state       <= S_CPU_ACC;
                    end
                end
                S_CPU_ACC: begin
                    r_bsram_en <= 1'b0;
                    r_bsram_we <= 1'b0;
                    // The access direction lives in the BSRAM we register; r_cpu_we may already hold a newer strobe
                    if (r_bsram_we) begin
                        r_cpu_valid <= 1'b1;
                        r_state     <= S_IDLE;
                    end else begin
                        r_state     <= S_CPU_RD;
                    end
                end
                S_CPU_RD: begin
                    r_cpu_rdata <= i_bsram_rdata;
                    r_cpu_valid <= 1'b1;
                    r_state     <= S_IDLE;
                end
                S_RV_LO: begin
                    r_bsram_addr  <= {r_rv_hw, 1'b1};
                    r_bsram_en    <= r_rv_we ? r_rv_ds[1] : 1'b1;
                    r_bsram_we    <= r_rv_we;
                    r_bsram_wdata <= r_rv_wdata[15:8];
                    r_state       <= S_RV_HI;
                end
                S_RV_HI: begin
                    r_bsram_en <= 1'b0;
                    r_bsram_we <= 1'b0;
                    if (!r_rv_we) begin
                        r_rv_rdata[7:0] <= i_bsram_rdata;
                    end
                    r_state <= S_RV_DONE;
                end
                S_RV_DONE: begin
                    if (!r_rv_we) begin
                        r_rv_rdata[15:8] <= i_bsram_rdata;
                    end
                    r_rv_ack <= ~r_rv_ack;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_bsram_en <= 1'b0;
                    r_bsram_we <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase

            // A fresh strobe takes priority over the clear at grant, so it stays queued
            if (w_cpu_stb) begin
                r_cpu_pend  <= 1'b1;
                r_cpu_off   <= w_cpu_off[LP_AW-1:0];
                r_cpu_we    <= i_cpu_we;
                r_cpu_wdata <= i_cpu_wdata;
            end
        end
    end

endmodule

// File: tb/tb_wram_arbiter.sv
// Directed bench for wram_arbiter with a behavioural one-cycle-read BSRAM.
// Inputs change 1ns after the rising edge and outputs are sampled at the same point.
// Every test is a task with inline comparisons against hand-computed values.
module tb_wram_arbiter;

    logic        clk;
    logic        rst;
    logic [15:0] cpu_addr;
    logic        cpu_re, cpu_we;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_valid;
    logic        rv_req, rv_ack;
    logic [22:0] rv_addr;
    logic        rv_we;
    logic [15:0] rv_wdata;
    logic [1:0]  rv_ds;
    logic [15:0] rv_rdata;
    logic        wram_load;
    logic        bs_en, bs_we;
    logic [12:0] bs_addr;
    logic [7:0]  bs_wdata;
    logic [7:0]  bs_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    wram_arbiter dut (
        .i_clk               (clk),
        .i_reset             (rst),
        .i_cpu_addr          (cpu_addr),
        .i_cpu_re            (cpu_re),
        .i_cpu_we            (cpu_we),
        .i_cpu_wdata         (cpu_wdata),
        .o_cpu_rdata         (cpu_rdata),
        .o_cpu_valid         (cpu_valid),
        .i_rv_req            (rv_req),
        .o_rv_req_ack        (rv_ack),
        .i_rv_addr           (rv_addr),
        .i_rv_we             (rv_we),
        .i_rv_wdata          (rv_wdata),
        .i_rv_ds             (rv_ds),
        .o_rv_rdata          (rv_rdata),
        .i_wram_load_ongoing (wram_load),
        .o_bsram_en          (bs_en),
        .o_bsram_we          (bs_we),
        .o_bsram_addr        (bs_addr),
        .o_bsram_wdata       (bs_wdata),
        .i_bsram_rdata       (bs_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // BSRAM model: byte i starts as i ^ 8'h5A
    logic [7:0] mem [0:8191];
    logic       mem_ready = 1'b0;
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 8192; i++) mem[i] <= 8'(i) ^ 8'h5A;
            mem_ready <= 1'b1;
        end else if (bs_en) begin
            if (bs_we) mem[bs_addr] <= bs_wdata;
            else       bs_rdata     <= mem[bs_addr];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; cpu_addr = 16'h6000; cpu_re = 0; cpu_we = 0; cpu_wdata = 0;
        rv_req = 1'b1; rv_addr = 23'h066000; rv_we = 0; rv_wdata = 0; rv_ds = 0; wram_load = 0;
        tick(); tick();
        n_checks++; if (bs_en !== 1'b0 || bs_we !== 1'b0) begin n_fail++; $display("FAIL reset_en_we: got en=%b we=%b want 0/0", bs_en, bs_we); end
        n_checks++; if (bs_addr !== 13'h0 || bs_wdata !== 8'h0) begin n_fail++; $display("FAIL reset_addr_wdata: got %h/%h want 0/0", bs_addr, bs_wdata); end
        n_checks++; if (cpu_valid !== 1'b0 || cpu_rdata !== 8'h0) begin n_fail++; $display("FAIL reset_cpu_out: got v=%b d=%h want 0/00", cpu_valid, cpu_rdata); end
        n_checks++; if (rv_rdata !== 16'h0) begin n_fail++; $display("FAIL reset_rv_rdata: got %h want 0000", rv_rdata); end
        n_checks++; if (rv_ack !== 1'b1) begin n_fail++; $display("FAIL reset_ack_follows_req: got %b want 1", rv_ack); end
        rst = 1'b0;
        tick(); tick(); tick();
        n_checks++; if (rv_ack !== 1'b1 || bs_en !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle: got ack=%b en=%b want 1/0", rv_ack, bs_en); end
    endtask

    task automatic test_cpu_write_read();
        cpu_addr = 16'h6005; cpu_wdata = 8'hA5; cpu_we = 1; tick(); cpu_we = 0;
        n_checks++; if (bs_en !== 1'b0) begin n_fail++; $display("FAIL cpu_wr_n_idle: got en=%b want 0", bs_en); end
        tick();
        n_checks++; if ({bs_en, bs_we, bs_addr, bs_wdata} !== {1'b1, 1'b1, 13'h0005, 8'hA5}) begin n_fail++; $display("FAIL cpu_wr_access: got en=%b we=%b a=%h d=%h want 1 1 0005 a5", bs_en, bs_we, bs_addr, bs_wdata); end
        tick();
        n_checks++; if (cpu_valid !== 1'b1 || bs_en !== 1'b0) begin n_fail++; $display("FAIL cpu_wr_valid_n2: got v=%b en=%b want 1/0", cpu_valid, bs_en); end
        tick();
        n_checks++; if (cpu_valid !== 1'b0 || mem[13'h0005] !== 8'hA5) begin n_fail++; $display("FAIL cpu_wr_done: got v=%b mem=%h want 0/a5", cpu_valid, mem[13'h0005]); end
        cpu_re = 1; tick(); cpu_re = 0;
        tick();
        n_checks++; if ({bs_en, bs_we, bs_addr} !== {1'b1, 1'b0, 13'h0005}) begin n_fail++; $display("FAIL cpu_rd_access: got en=%b we=%b a=%h want 1 0 0005", bs_en, bs_we, bs_addr); end
        tick();
        n_checks++; if (cpu_valid !== 1'b0) begin n_fail++; $display("FAIL cpu_rd_early_valid: got %b want 0", cpu_valid); end
        tick();
        n_checks++; if (cpu_valid !== 1'b1 || cpu_rdata !== 8'hA5) begin n_fail++; $display("FAIL cpu_rd_n3: got v=%b d=%h want 1/a5", cpu_valid, cpu_rdata); end
        tick();
        n_checks++; if (cpu_valid !== 1'b0 || cpu_rdata !== 8'hA5) begin n_fail++; $display("FAIL cpu_rd_hold: got v=%b d=%h want 0/a5", cpu_valid, cpu_rdata); end
        // Top byte of the window
        cpu_addr = 16'h7FFF; cpu_wdata = 8'h3C; cpu_we = 1; tick(); cpu_we = 0;
        tick();
        n_checks++; if ({bs_en, bs_we, bs_addr} !== {1'b1, 1'b1, 13'h1FFF}) begin n_fail++; $display("FAIL cpu_top_of_window: got en=%b we=%b a=%h want 1 1 1fff", bs_en, bs_we, bs_addr); end
        tick(); tick();
    endtask

    task automatic test_out_of_window();
        logic [15:0] addrs [2];
        logic        seen_en, seen_v;
        addrs[0] = 16'h8000; addrs[1] = 16'h5FFF;
        for (int k = 0; k < 2; k++) begin
            seen_en = 0; seen_v = 0;
            cpu_addr = addrs[k]; cpu_re = 1; cpu_we = 1; tick(); cpu_re = 0; cpu_we = 0;
            for (int c = 0; c < 5; c++) begin
                seen_en |= bs_en; seen_v |= cpu_valid;
                tick();
            end
            n_checks++; if (seen_en !== 1'b0 || seen_v !== 1'b0) begin n_fail++; $display("FAIL cpu_out_of_window %h: got en=%b valid=%b want 0/0", addrs[k], seen_en, seen_v); end
        end
        cpu_addr = 16'h6000;
        // RV toggle one byte past the window is never acknowledged
        seen_en = 0;
        rv_addr = 23'h068000; rv_we = 0; rv_req = ~rv_req;
        for (int c = 0; c < 6; c++) begin
            tick();
            seen_en |= bs_en;
        end
        n_checks++; if (seen_en !== 1'b0 || rv_ack === rv_req) begin n_fail++; $display("FAIL rv_out_of_window: got en=%b ack=%b want en 0 ack!=%b", seen_en, rv_ack, rv_req); end
        rv_req = ~rv_req; tick(); tick();
    endtask

    task automatic test_rv_write_read();
        rv_addr = 23'h066010; rv_we = 1; rv_wdata = 16'hBEEF; rv_ds = 2'b01; rv_req = ~rv_req;
        tick();
        tick();
        n_checks++; if ({bs_en, bs_we, bs_addr, bs_wdata} !== {1'b1, 1'b1, 13'h0010, 8'hEF}) begin n_fail++; $display("FAIL rv_wr_lo: got en=%b we=%b a=%h d=%h want 1 1 0010 ef", bs_en, bs_we, bs_addr, bs_wdata); end
        tick();
        n_checks++; if (bs_en !== 1'b0 || bs_addr !== 13'h0011) begin n_fail++; $display("FAIL rv_wr_hi_masked: got en=%b a=%h want 0/0011", bs_en, bs_addr); end
        tick();
        n_checks++; if (rv_ack === rv_req) begin n_fail++; $display("FAIL rv_wr_early_ack: got ack=%b want !=%b", rv_ack, rv_req); end
        tick();
        n_checks++; if (rv_ack !== rv_req) begin n_fail++; $display("FAIL rv_wr_ack_m4: got ack=%b want %b", rv_ack, rv_req); end
        n_checks++; if (mem[13'h0010] !== 8'hEF || mem[13'h0011] !== 8'h4B) begin n_fail++; $display("FAIL rv_wr_mem: got %h %h want ef 4b", mem[13'h0010], mem[13'h0011]); end
        rv_we = 0; rv_req = ~rv_req;
        tick(); tick();
        n_checks++; if ({bs_en, bs_we, bs_addr} !== {1'b1, 1'b0, 13'h0010}) begin n_fail++; $display("FAIL rv_rd_lo: got en=%b we=%b a=%h want 1 0 0010", bs_en, bs_we, bs_addr); end
        tick();
        n_checks++; if ({bs_en, bs_we, bs_addr} !== {1'b1, 1'b0, 13'h0011}) begin n_fail++; $display("FAIL rv_rd_hi: got en=%b we=%b a=%h want 1 0 0011", bs_en, bs_we, bs_addr); end
        tick(); tick();
        n_checks++; if (rv_ack !== rv_req || rv_rdata !== 16'h4BEF) begin n_fail++; $display("FAIL rv_rd_data: got ack=%b d=%h want %b 4bef", rv_ack, rv_rdata, rv_req); end
        tick();
    endtask

    task automatic test_simultaneous();
        int cpu_cyc, rv_cyc;
        for (int ld = 0; ld < 2; ld++) begin
            cpu_cyc = 0; rv_cyc = 0;
            wram_load = ld[0];
            cpu_addr = 16'h6020; cpu_wdata = 8'h11; cpu_we = 1;
            rv_addr = 23'h066030; rv_we = 0; rv_ds = 2'b11; rv_req = ~rv_req;
            tick(); cpu_we = 0;
            for (int c = 1; c <= 8; c++) begin
                tick();
                if (bs_en && bs_addr == 13'h0020 && cpu_cyc == 0) cpu_cyc = c;
                if (bs_en && bs_addr == 13'h0030 && rv_cyc == 0) rv_cyc = c;
            end
            n_checks++; if (cpu_cyc != (ld ? 5 : 1) || rv_cyc != (ld ? 1 : 3)) begin n_fail++; $display("FAIL arb_order load=%0d: got cpu@%0d rv@%0d want cpu@%0d rv@%0d", ld, cpu_cyc, rv_cyc, ld ? 5 : 1, ld ? 1 : 3); end
            n_checks++; if (rv_ack !== rv_req || rv_rdata !== 16'h6B6A) begin n_fail++; $display("FAIL arb_rv_result load=%0d: got ack=%b d=%h want %b 6b6a", ld, rv_ack, rv_rdata, rv_req); end
        end
        wram_load = 0;
        tick();
    endtask

    task automatic test_maxwait();
        int nvalid, ncpu;
        nvalid = 0; ncpu = 0;
        cpu_addr = 16'h6040; rv_addr = 23'h066050; rv_we = 0; rv_ds = 2'b11;
        for (int t = 0; t < 16; t++) begin
            cpu_re = ((t % 3) == 0) && (t <= 12);
            if (t == 0) rv_req = ~rv_req;
            tick();
            cpu_re = 0;
            if (cpu_valid) nvalid++;
            if (t < 10 && bs_en && bs_addr == 13'h0040) ncpu++;
            if (t == 10) begin
                n_checks++; if ({bs_en, bs_we, bs_addr} !== {1'b1, 1'b0, 13'h0050}) begin n_fail++; $display("FAIL maxwait_forced_lo: got en=%b we=%b a=%h want 1 0 0050", bs_en, bs_we, bs_addr); end
            end
            if (t == 11) begin
                n_checks++; if ({bs_en, bs_addr} !== {1'b1, 13'h0051}) begin n_fail++; $display("FAIL maxwait_hi_no_overlap: got en=%b a=%h want 1 0051", bs_en, bs_addr); end
            end
            if (t == 12) begin
                n_checks++; if (rv_ack === rv_req) begin n_fail++; $display("FAIL maxwait_early_ack: got ack=%b want !=%b", rv_ack, rv_req); end
            end
            if (t == 13) begin
                n_checks++; if (rv_ack !== rv_req || rv_rdata !== 16'h0B0A) begin n_fail++; $display("FAIL maxwait_ack: got ack=%b d=%h want %b 0b0a", rv_ack, rv_rdata, rv_req); end
                n_checks++; if (nvalid != 3 || ncpu != 3) begin n_fail++; $display("FAIL maxwait_cpu_first: got valids=%0d grants=%0d want 3/3", nvalid, ncpu); end
            end
        end
        for (int c = 0; c < 6; c++) tick();
    endtask

    task automatic test_reset_mid_rv();
        logic seen_en;
        seen_en = 0;
        rv_addr = 23'h066070; rv_we = 1; rv_wdata = 16'h1234; rv_ds = 2'b11; rv_req = ~rv_req;
        tick(); tick(); tick();
        n_checks++; if ({bs_en, bs_we, bs_addr} !== {1'b1, 1'b1, 13'h0071}) begin n_fail++; $display("FAIL rst_mid_in_hi: got en=%b we=%b a=%h want 1 1 0071", bs_en, bs_we, bs_addr); end
        rst = 1'b1;
        #1;
        n_checks++; if (bs_en !== 1'b0 || bs_we !== 1'b0) begin n_fail++; $display("FAIL rst_mid_en: got en=%b we=%b want 0/0", bs_en, bs_we); end
        tick(); tick();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            seen_en |= bs_en;
        end
        n_checks++; if (seen_en !== 1'b0 || rv_ack !== rv_req) begin n_fail++; $display("FAIL rst_mid_after: got en=%b ack=%b want 0 %b", seen_en, rv_ack, rv_req); end
        n_checks++; if (mem[13'h0070] !== 8'h34 || mem[13'h0071] !== 8'h2B) begin n_fail++; $display("FAIL rst_mid_mem: got %h %h want 34 2b", mem[13'h0070], mem[13'h0071]); end
    endtask

    initial begin
        test_reset();
        test_cpu_write_read();
        test_out_of_window();
        test_rv_write_read();
        test_simultaneous();
        test_maxwait();
        test_reset_mid_rv();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
